cache_mem_arbiter: RTL and testbench

//  Shares one memory port between two cache controllers: port 0 = I-cache, port 1 = D-cache.

---
 rtl/cache_mem_arbiter_pkg.sv | 35 +++
 rtl/cache_arb_sat_cnt.sv | 30 +++
 rtl/cache_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cache_def
// Purpose  : Memory-interface types shared by the cache controllers, the
//            memory model and the cache/memory arbiter.
//            mem_req_type  : {addr[31:0], data[127:0], rw, valid}
//            mem_data_type : {data[127:0], ready}
//            arb_state_e   : arbiter FSM states (2-bit)
//            ARB_NPORTS    : number of arbitrated requesters
// Revision : 1.0 - initial release
// ============================================================================
package cache_def;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;     // 1 = write-back, 0 = refill read
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;  // one-cycle pulse qualifying data
    } mem_data_type;

    localparam int ARB_NPORTS = 2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/cache_arb_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : cache_arb_sat_cnt
// Purpose  : Saturating event counter for arbiter statistics. Counts one
//            per cycle while inc is high and sticks at all-ones.
// Ports    : clk    in  clock
//            rst_n  in  asynchronous active-low reset (clears to 0)
//            inc    in  count enable
//            out    out STAT_W-bit count
// Revision : 1.0 - initial release
// ============================================================================
module cache_arb_sat_cnt #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [STAT_W-1:0] out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else if (inc && (out != {STAT_W{1'b1}})) begin
            out <= out + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Purpose  : Shares one memory port between the I-cache (port 0) and the
//            D-cache (port 1). Round-robin grant, each grant locked for one
//            complete memory transaction (until mem_rsp.ready).
// Ports    : clk, rst_n      clock / asynchronous active-low reset
//            req0, rsp0      I-cache request / response
//            req1, rsp1      D-cache request / response
//            mem_req,mem_rsp memory-side request / response
//            grant_id        current or last owner (debug)
//            busy            a transaction is outstanding
//            gnt_cnt0/1, wait_cnt  statistics (CACHE_ARB_STATS_EN only)
// Config   : define CACHE_ARB_STATS_EN to add the saturating stats counters.
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter
    import cache_def::*;
#(
    parameter int RESET_PRIO = 0,
    parameter int STAT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  mem_req_type       req0,
    output mem_data_type      rsp0,
    input  mem_req_type       req1,
    output mem_data_type      rsp1,
    output mem_req_type       mem_req,
    input  mem_data_type      mem_rsp,
`ifdef CACHE_ARB_STATS_EN
    output logic [STAT_W-1:0] gnt_cnt0,
    output logic [STAT_W-1:0] gnt_cnt1,
    output logic [STAT_W-1:0] wait_cnt,
`endif
    output logic              grant_id,
    output logic              busy
);

    localparam logic RESET_PORT = (RESET_PRIO != 0);

    arb_state_e            state, state_nxt;
    logic                  last_gnt;
    logic                  grant_id_q;
    logic                  take;      // a grant is being issued this cycle
    logic                  gnt_nxt;   // port receiving that grant
    logic                  owner;     // port owning the current grant
    logic [ARB_NPORTS-1:0] valid;

    assign valid = {req1.valid, req0.valid};
    assign owner = (state == ARB_GNT1);

    // Next-state / grant selection
    always_comb begin
        state_nxt = state;
        gnt_nxt   = last_gnt;
        take      = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (valid[0] && valid[1]) begin
                    take    = 1'b1;
                    gnt_nxt = ~last_gnt;
                end else if (valid[0]) begin
                    take    = 1'b1;
                    gnt_nxt = 1'b0;
                end else if (valid[1]) begin
                    take    = 1'b1;
                    gnt_nxt = 1'b1;
                end
            end
            ARB_GNT0, ARB_GNT1: begin
                // Grant is held until the memory reply, even if the owner
                // has already dropped valid. On completion, hand over
                // directly to a waiting peer without an idle bubble.
                if (mem_rsp.ready) begin
                    if (valid[~owner]) begin
                        take    = 1'b1;
                        gnt_nxt = ~owner;
                    end else begin
                        state_nxt = ARB_IDLE;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
        if (take) begin
            state_nxt = gnt_nxt ? ARB_GNT1 : ARB_GNT0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_gnt   <= ~RESET_PORT;
            grant_id_q <= RESET_PORT;
        end else begin
            state <= state_nxt;
            if (take) begin
                last_gnt   <= gnt_nxt;
                grant_id_q <= gnt_nxt;
            end
        end
    end

    // Datapath muxing: owner's request goes straight to memory, the memory
    // reply goes straight back to the owner, the other side sees zeros.
    always_comb begin
        mem_req = '0;
        rsp0    = '0;
        rsp1    = '0;
        unique case (state)
            ARB_GNT0: begin
                mem_req = req0;
                rsp0    = mem_rsp;
            end
            ARB_GNT1: begin
                mem_req = req1;
                rsp1    = mem_rsp;
            end
            default: ;
        endcase
    end

    assign grant_id = grant_id_q;
    assign busy     = (state != ARB_IDLE);

`ifdef CACHE_ARB_STATS_EN
    logic inc_g0, inc_g1, inc_wait;
    logic wait0, wait1;

    assign inc_g0 = take && !gnt_nxt;
    assign inc_g1 = take &&  gnt_nxt;
    // A port is waiting when it is valid, not the current owner and not
    // the port being granted this cycle.
    assign wait0  = valid[0] && !(busy && !owner) && !inc_g0;
    assign wait1  = valid[1] && !(busy &&  owner) && !inc_g1;
    assign inc_wait = wait0 || wait1;

    cache_arb_sat_cnt #(.STAT_W(STAT_W)) u_cnt_gnt0 (
        .clk(clk), .rst_n(rst_n), .inc(inc_g0), .out(gnt_cnt0)
    );
    cache_arb_sat_cnt #(.STAT_W(STAT_W)) u_cnt_gnt1 (
        .clk(clk), .rst_n(rst_n), .inc(inc_g1), .out(gnt_cnt1)
    );
    cache_arb_sat_cnt #(.STAT_W(STAT_W)) u_cnt_wait (
        .clk(clk), .rst_n(rst_n), .inc(inc_wait), .out(wait_cnt)
    );
`else
    logic unused_stat_cfg;
    assign unused_stat_cfg = (STAT_W != 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_mem_arbiter
// Purpose  : Self-checking bench for cache_mem_arbiter: a directed cycle
//            table, reset/fairness sequences and randomized requesters with
//            a reactive memory, all checked against a transaction-level
//            reference model. Stats counters are checked when
//            CACHE_ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;
    import cache_def::*;

    localparam int RP     = 0;
    localparam int SW     = 2;
    localparam int SATMAX = (1 << SW) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    mem_req_type  req0, req1, mem_req;
    mem_data_type rsp0, rsp1, mem_rsp;
    logic         grant_id, busy;
`ifdef CACHE_ARB_STATS_EN
    logic [SW-1:0] gnt_cnt0, gnt_cnt1, wait_cnt;
`endif

    cache_mem_arbiter #(.RESET_PRIO(RP), .STAT_W(SW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .rsp0     (rsp0),
        .req1     (req1),
        .rsp1     (rsp1),
        .mem_req  (mem_req),
        .mem_rsp  (mem_rsp),
`ifdef CACHE_ARB_STATS_EN
        .gnt_cnt0 (gnt_cnt0),
        .gnt_cnt1 (gnt_cnt1),
        .wait_cnt (wait_cnt),
`endif
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [161:0] act, input logic [161:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int m_owner;            // -1 = nobody holds the memory port
    int m_last;             // port granted most recently
    int m_gid;
    int m_g0, m_g1, m_wait;

    function automatic int sat_inc(input int v);
        return (v < SATMAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = (RP == 0) ? 1 : 0;
        m_gid   = RP;
        m_g0 = 0; m_g1 = 0; m_wait = 0;
    endtask

    task automatic check_outputs(input string tag);
        mem_req_type  e_mreq;
        mem_data_type e_r0, e_r1;
        e_mreq = '0; e_r0 = '0; e_r1 = '0;
        if (m_owner == 0) begin e_mreq = req0; e_r0 = mem_rsp; end
        if (m_owner == 1) begin e_mreq = req1; e_r1 = mem_rsp; end
        chk({tag, ".mem_req"},  mem_req, e_mreq);
        chk({tag, ".rsp0"},     rsp0, e_r0);
        chk({tag, ".rsp1"},     rsp1, e_r1);
        chk({tag, ".busy"},     busy, (m_owner >= 0));
        chk({tag, ".grant_id"}, grant_id, m_gid[0]);
`ifdef CACHE_ARB_STATS_EN
        chk({tag, ".gnt_cnt0"}, gnt_cnt0, m_g0[SW-1:0]);
        chk({tag, ".gnt_cnt1"}, gnt_cnt1, m_g1[SW-1:0]);
        chk({tag, ".wait_cnt"}, wait_cnt, m_wait[SW-1:0]);
`endif
    endtask

    task automatic model_step();
        bit v[2];
        int pick, prev;
        v[0] = req0.valid; v[1] = req1.valid;
        pick = -1;
        prev = m_owner;
        if (m_owner < 0) begin
            if (v[0] && v[1]) pick = 1 - m_last;
            else if (v[0])    pick = 0;
            else if (v[1])    pick = 1;
        end else if (mem_rsp.ready) begin
            if (v[1 - m_owner]) pick = 1 - m_owner;
            else                m_owner = -1;
        end
        if ((v[0] && prev != 0 && pick != 0) || (v[1] && prev != 1 && pick != 1))
            m_wait = sat_inc(m_wait);
        if (pick >= 0) begin
            m_owner = pick;
            m_last  = pick;
            m_gid   = pick;
            if (pick == 0) m_g0 = sat_inc(m_g0);
            else           m_g1 = sat_inc(m_g1);
        end
    endtask

    // ---------------- stimulus environment ----------------
    bit           mem_pend;
    int           mem_cnt;
    logic [127:0] mem_pdata;
    bit           saw_rdy[2];
    int           gid_log[$];

    task automatic do_reset();
        rst_n   = 1'b0;
        req0    = '0; req1 = '0; mem_rsp = '0;
        mem_pend = 0; saw_rdy[0] = 0; saw_rdy[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic mem_req_type new_req();
        mem_req_type r;
        r.addr  = $urandom;
        r.data  = {$urandom, $urandom, $urandom, $urandom};
        r.rw    = $urandom_range(0, 1);
        r.valid = 1'b1;
        return r;
    endfunction

    // One cycle of random traffic: update inputs at the falling edge, check,
    // advance the model to what the next rising edge must produce.
    task automatic env_cycle(input int prob, input bit fast_mem, input string tag);
        if (req0.valid && saw_rdy[0]) req0.valid = 1'b0;
        else if (!req0.valid && $urandom_range(0, 99) < prob) req0 = new_req();
        if (req1.valid && saw_rdy[1]) req1.valid = 1'b0;
        else if (!req1.valid && $urandom_range(0, 99) < prob) req1 = new_req();
        mem_rsp = '0;
        if (mem_pend && mem_cnt == 0) begin
            mem_rsp  = {mem_pdata, 1'b1};
            mem_pend = 0;
        end else if (mem_pend) begin
            mem_cnt--;
        end else if (m_owner < 0 && $urandom_range(0, 15) == 0) begin
            mem_rsp = {$urandom, $urandom, $urandom, $urandom, 1'b1};
        end
        #1;
        check_outputs(tag);
        saw_rdy[0] = rsp0.ready;
        saw_rdy[1] = rsp1.ready;
        if (rsp0.ready || rsp1.ready) gid_log.push_back(int'(grant_id));
        if (!mem_pend && !mem_rsp.ready && mem_req.valid) begin
            mem_pend  = 1;
            mem_cnt   = fast_mem ? 0 : $urandom_range(0, 3);
            mem_pdata = {$urandom, $urandom, $urandom, mem_req.addr};
        end
        model_step();
        @(negedge clk);
    endtask

    // ---------------- directed cycle table ----------------
    typedef struct {
        bit       v0, v1, rw1, rdy;
        bit [7:0] rdat;
        bit       e_mv;
        int       e_src;   // 0 none, 1 req0 forwarded, 2 req1 forwarded
        bit       e_r0, e_r1, e_busy, e_gid;
    } vec_t;

    function automatic vec_t mk(bit v0, bit v1, bit rw1, bit rdy, bit [7:0] rdat,
                                bit e_mv, int e_src, bit e_r0, bit e_r1, bit e_busy, bit e_gid);
        vec_t t;
        t.v0 = v0; t.v1 = v1; t.rw1 = rw1; t.rdy = rdy; t.rdat = rdat;
        t.e_mv = e_mv; t.e_src = e_src; t.e_r0 = e_r0; t.e_r1 = e_r1;
        t.e_busy = e_busy; t.e_gid = e_gid;
        return t;
    endfunction

    localparam logic [31:0]  A0 = 32'h0000_4000;
    localparam logic [31:0]  A1 = 32'h0000_8000;
    localparam logic [127:0] D1 = {4{32'h1234_5678}};

    initial begin
        vec_t         tv[16];
        mem_req_type  e_mreq;
        mem_data_type e_rsp, e_zero;
        logic [127:0] rd;
        int           budget;
        int           exp_seq[6];

        //      v0 v1 rw rdy dat   mv src r0 r1 bsy gid
        tv[0]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        tv[2]  = mk(1, 1, 1, 0, 8'h00, 1, 1, 0, 0, 1, 0);
        tv[3]  = mk(1, 1, 1, 1, 8'hAA, 1, 1, 1, 0, 1, 0);
        tv[4]  = mk(0, 1, 1, 0, 8'h00, 1, 2, 0, 0, 1, 1);
        tv[5]  = mk(0, 1, 1, 0, 8'h00, 1, 2, 0, 0, 1, 1);
        tv[6]  = mk(0, 1, 1, 1, 8'h55, 1, 2, 0, 1, 1, 1);
        tv[7]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
        tv[8]  = mk(0, 0, 0, 1, 8'h33, 0, 0, 0, 0, 0, 1);
        tv[9]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
        tv[10] = mk(1, 0, 0, 0, 8'h00, 1, 1, 0, 0, 1, 0);
        tv[11] = mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0);
        tv[12] = mk(0, 1, 0, 1, 8'h77, 0, 1, 1, 0, 1, 0);
        tv[13] = mk(0, 1, 0, 0, 8'h00, 1, 2, 0, 0, 1, 1);
        tv[14] = mk(0, 1, 0, 1, 8'h99, 1, 2, 0, 1, 1, 1);
        tv[15] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1);

        // ---- reset values ----
        rst_n = 1'b0;
        req0 = '0; req1 = '0; mem_rsp = '0;
        @(negedge clk);
        chk("rst.mem_req", mem_req, '0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.grant_id", grant_id, RP[0]);
        rst_n = 1'b1;
        model_reset();

        // ---- directed table ----
        e_zero = '0;
        for (int i = 0; i < 16; i++) begin
            rd      = {16{tv[i].rdat}};
            req0    = {A0, 128'h0, 1'b0, tv[i].v0};
            req1    = {A1, D1, tv[i].rw1, tv[i].v1};
            mem_rsp = {rd, tv[i].rdy};
            #1;
            e_mreq = '0;
            if (tv[i].e_src == 1) e_mreq = {A0, 128'h0, 1'b0, tv[i].e_mv};
            if (tv[i].e_src == 2) e_mreq = {A1, D1, tv[i].rw1, tv[i].e_mv};
            chk($sformatf("tbl%0d.mem_req", i), mem_req, e_mreq);
            e_rsp = tv[i].e_r0 ? {rd, 1'b1} : e_zero;
            chk($sformatf("tbl%0d.rsp0", i), rsp0, e_rsp);
            e_rsp = tv[i].e_r1 ? {rd, 1'b1} : e_zero;
            chk($sformatf("tbl%0d.rsp1", i), rsp1, e_rsp);
            chk($sformatf("tbl%0d.busy", i), busy, tv[i].e_busy);
            chk($sformatf("tbl%0d.grant_id", i), grant_id, tv[i].e_gid);
            @(negedge clk);
        end

        // ---- asynchronous reset in the middle of a GNT1 transaction ----
        do_reset();
        req1 = {A1, D1, 1'b1, 1'b1};
        #1; check_outputs("mid.idle");  model_step(); @(negedge clk);
        #1; check_outputs("mid.gnt1");  model_step(); @(negedge clk);
        mem_rsp = {{16{8'hC3}}, 1'b1};
        #1;
        rst_n = 1'b0;      // no clock edge here
        #1;
        chk("arst.mem_req.valid", mem_req.valid, 1'b0);
        chk("arst.rsp0.ready", rsp0.ready, 1'b0);
        chk("arst.rsp1.ready", rsp1.ready, 1'b0);
        chk("arst.busy", busy, 1'b0);
        chk("arst.grant_id", grant_id, RP[0]);
`ifdef CACHE_ARB_STATS_EN
        chk("arst.gnt_cnt1", gnt_cnt1, '0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mem_rsp = '0;
        req1 = '0;
        req0 = {A0, 128'h0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            #1; check_outputs($sformatf("post_rst%0d", i)); model_step(); @(negedge clk);
        end

        // ---- fairness: both ports continuously requesting ----
        do_reset();
        gid_log.delete();
        budget = 0;
        while (gid_log.size() < 6 && budget < 200) begin
            env_cycle(100, 1'b1, "fair");
            budget++;
        end
        chk("fair.completed", (gid_log.size() >= 6), 1'b1);
        exp_seq = '{0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 6 && i < gid_log.size(); i++)
            chk($sformatf("fair.gid%0d", i), gid_log[i], exp_seq[i]);

        // ---- randomized traffic ----
        do_reset();
        for (int i = 0; i < 1500; i++) env_cycle(30, 1'b0, "rnd");
        do_reset();
        for (int i = 0; i < 1500; i++) env_cycle(60, 1'b0, "rnd2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
